// File: rtl/reg_cmd_decoder.sv
// -----------------------------------------------------------------------------
// reg_cmd_decoder
//
// Upstream feeder for the register bank. Parses a 32-bit command stream into
// register-write packets and forwards the payload words as an AXIS stream.
// Each packet starts with a header word:
//     [31:28]            opcode
//     [23:16]            payload word count (0..255)
//     [INDEX_WIDTH-1:0]  start register index
// All other header bits are ignored. A header with OP_REG_WRITE whose range
// fits inside the bank is forwarded. A header with a bad opcode or an
// out-of-range span is swallowed together with its payload, and it raises the
// sticky error flag. A zero-count header is consumed silently.
//
// Ports
//     aclk           clock
//     reset          asynchronous, active-high reset
//     s_axis_tvalid  command word valid
//     s_axis_tready  command word accepted when high together with tvalid
//     s_axis_tdata   command word (header or payload)
//     m_axis_tvalid  register payload beat valid
//     m_axis_tready  downstream ready
//     m_axis_tdata   register value
//     m_axis_tuser   start register index of the current packet
//     m_axis_tlast   last payload beat of the packet
//     busy           high while a packet is being parsed or a beat is pending
//     error          sticky discard flag, cleared only by reset
//     pkt_count      packets fully forwarded, wraps at 16 bits
//
// State table
//     state       | meaning
//     ------------+-----------------------------------------------------------
//     ST_HDR      | waiting for a header word
//     ST_PAYLOAD  | forwarding payload words of a valid write packet
//     ST_DISCARD  | dropping payload words of a rejected packet
// -----------------------------------------------------------------------------
module reg_cmd_decoder #(
    parameter int          BANK_SIZE    = 8,
    parameter logic [3:0]  OP_REG_WRITE = 4'h1
) (
    input  logic                                 aclk,
    input  logic                                 reset,

    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic [31:0]                          s_axis_tdata,

    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic [31:0]                          m_axis_tdata,
    output logic [$clog2(BANK_SIZE)-1:0]         m_axis_tuser,
    output logic                                 m_axis_tlast,

    output logic                                 busy,
    output logic                                 error,
    output logic [15:0]                          pkt_count
);

    localparam int INDEX_WIDTH = $clog2(BANK_SIZE);
    // Wide enough that start + count can never wrap.
    localparam int SUM_WIDTH   = INDEX_WIDTH + 9;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [7:0]              remaining_q;
    logic [7:0]              remaining_d;
    logic [INDEX_WIDTH-1:0]  tuser_q;
    logic [INDEX_WIDTH-1:0]  tuser_d;

    logic                    out_valid_q;
    logic [31:0]             out_data_q;
    logic [INDEX_WIDTH-1:0]  out_user_q;
    logic                    out_last_q;

    logic                    error_q;
    logic [15:0]             pkt_count_q;

    logic                    s_ready;
    logic                    accept;
    logic                    load_out;
    logic                    set_error;
    logic                    pkt_done;
    logic                    last_word;

    logic [3:0]              hdr_opcode;
    logic [7:0]              hdr_count;
    logic [INDEX_WIDTH-1:0]  hdr_start;
    logic [SUM_WIDTH-1:0]    hdr_end;
    logic                    hdr_ok;

    // -------------------------------------------------------------------------
    // Header field decode
    // -------------------------------------------------------------------------
    assign hdr_opcode = s_axis_tdata[31:28];
    assign hdr_count  = s_axis_tdata[23:16];
    assign hdr_start  = s_axis_tdata[INDEX_WIDTH-1:0];
    assign hdr_end    = SUM_WIDTH'(hdr_start) + SUM_WIDTH'(hdr_count);
    assign hdr_ok     = (hdr_opcode == OP_REG_WRITE) &&
                        (hdr_end <= SUM_WIDTH'(BANK_SIZE));

    // -------------------------------------------------------------------------
    // Input handshake. In PAYLOAD a word is only taken when the single output
    // stage can accept it in the same cycle, so no payload word is ever lost.
    // -------------------------------------------------------------------------
    always_comb begin
        s_ready = 1'b1;
        if (state_q == ST_PAYLOAD) begin
            s_ready = !out_valid_q || m_axis_tready;
        end
    end

    assign accept    = s_axis_tvalid && s_ready;
    assign last_word = (remaining_q == 8'd1);

    // -------------------------------------------------------------------------
    // FSM next-state and control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tuser_d     = tuser_q;
        load_out    = 1'b0;
        set_error   = 1'b0;
        pkt_done    = 1'b0;

        case (state_q)
            ST_HDR: begin
                if (accept && (hdr_count != 8'd0)) begin
                    remaining_d = hdr_count;
                    if (hdr_ok) begin
                        tuser_d = hdr_start;
                        state_d = ST_PAYLOAD;
                    end else begin
                        set_error = 1'b1;
                        state_d   = ST_DISCARD;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (accept) begin
                    load_out    = 1'b1;
                    remaining_d = remaining_q - 8'd1;
                    if (last_word) begin
                        pkt_done = 1'b1;
                        state_d  = ST_HDR;
                    end
                end
            end

            ST_DISCARD: begin
                if (accept) begin
                    remaining_d = remaining_q - 8'd1;
                    if (last_word) begin
                        state_d = ST_HDR;
                    end
                end
            end

            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HDR;
            remaining_q <= 8'd0;
            tuser_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            tuser_q     <= tuser_d;
        end
    end

    // -------------------------------------------------------------------------
    // Single-stage output register. Data fields only change on a load, which
    // keeps a stalled beat stable until its handshake.
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_data_q  <= s_axis_tdata;
            out_user_q  <= tuser_q;
            out_last_q  <= last_word;
        end else if (m_axis_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Status
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            error_q     <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            if (set_error) begin
                error_q <= 1'b1;
            end
            if (pkt_done) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tuser  = out_user_q;
    assign m_axis_tlast  = out_last_q;
    assign busy          = (state_q != ST_HDR) || out_valid_q;
    assign error         = error_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_reg_cmd_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for reg_cmd_decoder. Packets are described by their header; the
// expected beats, error flag and packet count are derived from the header
// fields with plain arithmetic and compared against the DUT output stream.
// -----------------------------------------------------------------------------
module tb_reg_cmd_decoder;

    localparam int BANK = 8;

    logic        aclk;
    logic        reset;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [2:0]  m_axis_tuser;
    logic        m_axis_tlast;
    logic        busy;
    logic        error;
    logic [15:0] pkt_count;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  exp_err  = 1'b0;
    int    exp_pkts = 0;
    int    rdy_mode = 0;
    logic  hold_v   = 1'b0;
    beat_t hold_b;

    reg_cmd_decoder #(.BANK_SIZE(BANK), .OP_REG_WRITE(4'h1)) dut (
        .aclk          (aclk),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .error         (error),
        .pkt_count     (pkt_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Random downstream backpressure when enabled.
    always @(posedge aclk) begin
        #1;
        if (rdy_mode == 1) m_axis_tready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: scoreboard of beats plus hold-stability while stalled.
    always @(negedge aclk) begin
        beat_t cur;
        beat_t e;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            cur = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
            if (hold_v && m_axis_tvalid) begin
                n_checks++;
                if (cur !== hold_b) begin
                    n_fail++;
                    $display("FAIL stall_stable: got %h, held %h", cur, hold_b);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got d=%h u=%0d l=%0b, expected none",
                             cur.d, cur.u, cur.l);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        n_fail++;
                        $display("FAIL beat: got d=%h u=%0d l=%0b, expected d=%h u=%0d l=%0b",
                                 cur.d, cur.u, cur.l, e.d, e.u, e.l);
                    end
                end
                hold_v = 1'b0;
            end else begin
                hold_v = m_axis_tvalid;
                hold_b = cur;
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Presents one word and returns 1 ns after the edge that accepted it.
    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge aclk);
            if (s_axis_tready) ok = 1'b1;
            @(posedge aclk);
            #1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: word %h not accepted, required acceptance", w);
        end
        s_axis_tvalid = 1'b0;
    endtask

    // Sends a header plus its payload words and records the expected outcome.
    task automatic send_packet(input logic [31:0] hdr, input bit gaps);
        int op, cnt, st;
        bit legal;
        logic [31:0] w;
        beat_t b;
        op    = int'(hdr / 32'h1000_0000);
        cnt   = int'((hdr / 32'h1_0000) % 256);
        st    = int'(hdr % BANK);
        legal = (cnt > 0) && (op == 1) && (st + cnt <= BANK);
        send_word(hdr);
        if (cnt > 0 && !legal) exp_err = 1'b1;
        for (int k = 0; k < cnt; k++) begin
            w = $urandom;
            if (legal) begin
                b.d = w;
                b.u = 3'(st);
                b.l = (k == cnt - 1);
                exp_q.push_back(b);
            end
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_word(w);
        end
        if (legal) exp_pkts++;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || m_axis_tvalid); i++) begin
            @(negedge aclk);
        end
        @(posedge aclk);
        #1;
        n_checks++;
        if (exp_q.size() != 0 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: %0d beats outstanding, tvalid=%b, required 0 and 0",
                     exp_q.size(), m_axis_tvalid);
            exp_q.delete();
        end
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'd0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge aclk);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h u=%0d l=%b, required all zero",
                     m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast);
        end
        n_checks++;
        if (error !== 1'b0 || pkt_count !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got err=%b cnt=%0d busy=%b, required 0 0 0",
                     error, pkt_count, busy);
        end
        reset = 1'b0;
        idle(2);
        n_checks++;
        if (s_axis_tready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got s_tready=%b busy=%b, required 1 0",
                     s_axis_tready, busy);
        end
    endtask

    task automatic test_basic();
        logic [31:0] w [3];
        beat_t b;
        rdy_mode = 0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            b.d = w[i];
            b.u = 3'd2;
            b.l = (i == 2);
            exp_q.push_back(b);
        end
        send_word(32'h1003_0002);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        for (int i = 0; i < 3; i++) begin
            send_word(w[i]);
            n_checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w[i] ||
                m_axis_tuser !== 3'd2 || m_axis_tlast !== (i == 2)) begin
                n_fail++;
                $display("FAIL basic_latency beat %0d: got v=%b d=%h u=%0d l=%b, required v=1 d=%h u=2 l=%0b",
                         i, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, w[i], (i == 2));
            end
        end
        exp_pkts++;
        drain();
        n_checks++;
        if (pkt_count !== 16'(exp_pkts) || error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_status: got cnt=%0d err=%b busy=%b, required cnt=%0d err=0 busy=0",
                     pkt_count, error, busy, exp_pkts);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w [3];
        beat_t b;
        rdy_mode = 0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            b.d = w[i];
            b.u = 3'd2;
            b.l = (i == 2);
            exp_q.push_back(b);
        end
        send_word(32'h1003_0002);
        send_word(w[0]);
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w[1];
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            n_checks++;
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata !== w[0]) begin
                n_fail++;
                $display("FAIL stall_cycle %0d: got s_tready=%b v=%b d=%h, required 0 1 %h",
                         c, s_axis_tready, m_axis_tvalid, m_axis_tdata, w[0]);
            end
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        send_word(w[1]);
        send_word(w[2]);
        exp_pkts++;
        drain();
        n_checks++;
        if (pkt_count !== 16'(exp_pkts) || error !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_status: got cnt=%0d err=%b, required cnt=%0d err=0",
                     pkt_count, error, exp_pkts);
        end
    endtask

    task automatic test_zero_count();
        rdy_mode = 0;
        m_axis_tready = 1'b1;
        send_word(32'h1000_0003);
        n_checks++;
        if (busy !== 1'b0 || error !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_count: got busy=%b err=%b v=%b, required 0 0 0",
                     busy, error, m_axis_tvalid);
        end
        send_packet(32'h1008_0000, 1'b0);
        drain();
        n_checks++;
        if (pkt_count !== 16'(exp_pkts) || error !== 1'b0) begin
            n_fail++;
            $display("FAIL full_bank: got cnt=%0d err=%b, required cnt=%0d err=0",
                     pkt_count, error, exp_pkts);
        end
    endtask

    task automatic test_bad_opcode();
        rdy_mode = 0;
        m_axis_tready = 1'b1;
        send_packet(32'h2002_0000, 1'b0);
        n_checks++;
        if (error !== 1'b1 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_opcode: got err=%b v=%b busy=%b, required 1 0 0",
                     error, m_axis_tvalid, busy);
        end
        send_packet(32'h1001_0007, 1'b0);
        drain();
        n_checks++;
        if (pkt_count !== 16'(exp_pkts) || error !== exp_err) begin
            n_fail++;
            $display("FAIL bad_opcode_after: got cnt=%0d err=%b, required cnt=%0d err=%b",
                     pkt_count, error, exp_pkts, exp_err);
        end
    endtask

    task automatic test_range();
        rdy_mode = 0;
        m_axis_tready = 1'b1;
        send_packet(32'h1002_0007, 1'b0);
        n_checks++;
        if (pkt_count !== 16'(exp_pkts) || error !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL range: got cnt=%0d err=%b v=%b, required cnt=%0d err=1 v=0",
                     pkt_count, error, m_axis_tvalid, exp_pkts);
        end
        send_packet(32'h10FF_0000, 1'b0);
        send_packet(32'h1001_0003, 1'b0);
        drain();
        n_checks++;
        if (pkt_count !== 16'(exp_pkts) || error !== exp_err) begin
            n_fail++;
            $display("FAIL range_after: got cnt=%0d err=%b, required cnt=%0d err=%b",
                     pkt_count, error, exp_pkts, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        beat_t b;
        logic [31:0] w;
        rdy_mode = 0;
        m_axis_tready = 1'b1;
        send_word(32'h1004_0001);
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            b.d = w;
            b.u = 3'd1;
            b.l = 1'b0;
            exp_q.push_back(b);
            send_word(w);
        end
        #2;
        reset = 1'b1;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_pkts = 0;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0 ||
            error !== 1'b0 || pkt_count !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b l=%b d=%h err=%b cnt=%0d busy=%b, required all zero",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, error, pkt_count, busy);
        end
        @(negedge aclk);
        @(negedge aclk);
        reset = 1'b0;
        @(posedge aclk);
        #1;
        send_packet(32'h1001_0005, 1'b0);
        drain();
        n_checks++;
        if (pkt_count !== 16'd1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got cnt=%0d err=%b, required cnt=1 err=0",
                     pkt_count, error);
        end
    endtask

    task automatic test_random();
        logic [31:0] hdr;
        int op, cnt, st, r;
        rdy_mode = 1;
        for (int p = 0; p < 40; p++) begin
            op  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 1;
            r   = int'($urandom_range(0, 19));
            cnt = (r < 2) ? 0 : ((r == 19) ? 255 : int'($urandom_range(1, 9)));
            st  = int'($urandom_range(0, 7));
            hdr = 32'(op) * 32'h1000_0000 + ($urandom % 16) * 32'h100_0000 +
                  32'(cnt) * 32'h1_0000 + ($urandom % 8192) * 32'd8 + 32'(st);
            send_packet(hdr, 1'b1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        rdy_mode = 0;
        m_axis_tready = 1'b1;
        n_checks++;
        if (pkt_count !== 16'(exp_pkts) || error !== exp_err || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_status: got cnt=%0d err=%b busy=%b, required cnt=%0d err=%b busy=0",
                     pkt_count, error, busy, exp_pkts, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_count();
        test_bad_opcode();
        test_range();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_cmd_decoder.md
Name: reg_cmd_decoder

Overview:
- Upstream feeder for the register bank.
- Parses a 32-bit command stream into register-write packets and emits them as an AXIS stream: payload beats, tuser = start index, tlast on the final beat.
- Malformed or out-of-range commands are discarded, not forwarded, and raise a sticky error flag.

Parameters:
- BANK_SIZE, 8, number of 32-bit registers in the downstream bank; INDEX_WIDTH = $clog2(BANK_SIZE), localparam.
- OP_REG_WRITE, 4'h1, opcode value in header bits [31:28] that selects a register write.

Ports:
- aclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  command word valid.
- s_axis_tready  out  1  command word accepted when high together with tvalid.
- s_axis_tdata  in  32  command word (header or payload).
- m_axis_tvalid  out  1  register payload beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  32  register value.
- m_axis_tuser  out  INDEX_WIDTH  start register index of the current packet.
- m_axis_tlast  out  1  last payload beat of the packet.
- busy  out  1  high while not in HDR state or while m_axis_tvalid is high.
- error  out  1  sticky; set on any discarded command; cleared only by reset.
- pkt_count  out  16  number of packets fully forwarded; wraps 0xFFFF->0.

Behaviour:
- Header format:
  - [31:28] opcode.
  - [23:16] count, payload words 0..255.
  - [INDEX_WIDTH-1:0] start index; all other bits ignored.
- Reset (async assert, sync-safe release): state=HDR, remaining=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, error=0, pkt_count=0. A packet in flight is abandoned; no partial tlast is emitted.
- Output register: a single stage, "out_full" = m_axis_tvalid.
  - Register loads when empty or when m_axis_tready=1 in the same cycle.
  - m_axis_tvalid drops after a handshake if nothing new is loaded.
- s_axis_tready:
  - HDR: 1.
  - PAYLOAD: (!m_axis_tvalid || m_axis_tready).
  - DISCARD: 1.
- FSM, all transitions on an accepted input word only:
  - HDR, count==0, any opcode: header consumed, stay HDR, no output, no error.
  - HDR, opcode==OP_REG_WRITE and start+count <= BANK_SIZE (compare at INDEX_WIDTH+9 bits, no wrap): latch start into tuser_q, remaining=count, go PAYLOAD.
  - HDR, bad opcode or start+count > BANK_SIZE, count!=0: error<=1, remaining=count, go DISCARD.
  - PAYLOAD, each word: load output register with tdata, tuser=tuser_q, tlast=(remaining==1); remaining-=1. When remaining==1, go HDR and increment pkt_count on that accept.
  - DISCARD, each word: drop it; remaining-=1; when remaining==1, go HDR.
- Latency: a payload word accepted in cycle N is presented on m_axis in cycle N+1. Throughput is 1 word/cycle when m_axis_tready=1.
- A header following the last payload is accepted in the next cycle, even if the last beat is still stalled on m_axis. The stalled beat's tdata, tuser and tlast must stay stable until the handshake.
- m_axis_tuser is constant for every beat of a packet.
- m_axis_tdata, tuser and tlast hold their values while tvalid=1 and tready=0.
- Bounds:
  - count=BANK_SIZE with start=0 is legal.
  - count=255 with BANK_SIZE=8 goes to DISCARD.
  - Header bits outside the defined fields never affect behaviour.

Test Plan:
- Header 0x1003_0002 then words A,B,C, tready=1 -> beats A,B,C on cycles N+1..N+3, tuser=2 on all, tlast only on C, pkt_count=1, error=0.
- Same packet with m_axis_tready low for 3 cycles mid-packet -> s_axis_tready=0 while the output is full, no beat lost or duplicated, held data stable.
- Header 0x2002_0000 (bad opcode) + 2 words, then a valid 1-word write to index 7 -> error=1, no output for the first 2 words, one beat with tuser=7 and tlast=1.
- Header 0x1002_0007 (7+2>8) + 2 words -> discarded, error=1, pkt_count unchanged, next header parsed correctly.
- Header 0x1000_0003 (count 0) followed directly by 0x1008_0000 + 8 words -> no error; 8 beats, tuser=0, tlast on the 8th.
- Assert reset after 2 of 4 payload words -> m_axis_tvalid=0 immediately, state HDR, error=0, pkt_count=0; next header is processed from scratch.
